spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Round-robin arbiter and sequencer that shares the core's single SPI master (o_sclk/o_mosi/i_miso) between up to N_REQ on-chip requesters. It grants one requester at a time, drives that requester's chip select, and feeds its bytes into the SPI master one transfer at a time. It also returns each received byte to the owner and enforces a chip-select gap between owners. It sits between the MMIO/DMA requesters inside the core and the SPI shift engine.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1024, idle cycles tolerated while granted before forced release (only with SPI_ARB_TIMEOUT_EN)

Ports:
- i_clk  in  1  core clock; one clock domain only
- i_rst  in  1  reset; synchronous, active-high
- i_req  in  N_REQ  request ownership, one bit per requester
- i_lock  in  N_REQ  owner holds the bus while high
- i_wvalid  in  N_REQ  owner has a byte to send
- i_wdata  in  N_REQ*8  byte per requester; requester k uses bits [8k+7:8k]
- o_wready  out  N_REQ  byte accepted; one-hot, owner only
- o_rvalid  out  N_REQ  received byte valid; one-cycle pulse to owner
- o_rdata  out  8  received byte, shared by all requesters
- o_gnt  out  N_REQ  one-hot grant
- o_cs_n  out  N_REQ  chip selects, active-low
- o_spi_start  out  1  one-cycle start pulse to SPI master
- o_spi_wdata  out  8  byte to shift out
- i_spi_busy  in  1  SPI master busy
- i_spi_done  in  1  one-cycle pulse: transfer complete
- i_spi_rdata  in  8  byte shifted in, valid with i_spi_done
- o_timeout  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT, WAIT_DONE, RELEASE.
- Reset values:
  - state IDLE; round-robin pointer 0
  - o_gnt 0; o_cs_n all 1
  - o_wready 0; o_rvalid 0; o_rdata 0
  - o_spi_start 0; o_spi_wdata 0
  - o_timeout 0; timeout counter 0
- IDLE:
  - If any i_req bit is set, pick the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Register the owner, set o_gnt[owner]=1 and o_cs_n[owner]=0, then go to GRANT.
- GRANT, byte send:
  - o_wready[owner] = i_wvalid[owner] & ~i_spi_busy. This is combinational.
  - On the handshake edge, latch the byte into o_spi_wdata, pulse o_spi_start for the next cycle and go to WAIT_DONE.
- GRANT, release:
  - Condition: ~i_lock[owner] & ~i_wvalid[owner] -> RELEASE.
  - i_req is ignored once the requester is granted.
- WAIT_DONE:
  - On i_spi_done, latch i_spi_rdata into o_rdata, pulse o_rvalid[owner] on the next cycle and go to GRANT.
- RELEASE:
  - o_gnt=0 and all o_cs_n=1 for exactly one cycle.
  - Pointer becomes (owner+1) mod N_REQ; next state is IDLE.
- Non-owner i_wvalid and i_lock are ignored.

## Timing
- Request to grant: 1 cycle.
  - i_req high at edge n gives o_gnt and o_cs_n active after edge n+1.
- Byte accept to start: o_spi_start is high the cycle after the o_wready handshake.
- Done to read data: o_rvalid is high the cycle after i_spi_done.
- i_spi_done is honoured only in WAIT_DONE and ignored in every other state.
- Owner drops i_lock during WAIT_DONE: the transfer completes, o_rvalid is delivered, then release happens from GRANT.
- Back-to-back owners: chip select stays high for at least 2 cycles (RELEASE plus IDLE).
- No two o_cs_n bits are ever low at once; o_gnt is always one-hot or zero.
- Reset mid-transfer: all outputs return to their reset values after the reset edge. A pending i_spi_done is dropped and no o_rvalid is produced.
- Simultaneous requests: the pointer order decides the winner. Fairness guarantee: every requester is granted within N_REQ grants.

## Configuration
- SPI_ARB_TIMEOUT_EN defined:
  - The counter increments each GRANT cycle without a handshake and clears on a handshake or on leaving GRANT.
  - When it reaches TIMEOUT_CYCLES-1: pulse o_timeout and force RELEASE, even with i_lock high.
- SPI_ARB_TIMEOUT_EN undefined:
  - No counter is built; o_timeout is tied to 0.
  - A locked owner holds the bus indefinitely.

## Structure
- Package spi_arb_pkg holds:
  - state enum (IDLE, GRANT, WAIT_DONE, RELEASE)
  - N_REQ_MAX=8
  - owner index width $clog2(N_REQ_MAX)
- Sub-module rr_picker is combinational: request vector plus pointer in, one-hot grant plus index out.
- All registers live in spi_bus_arbiter.

## Test plan
- Reset then i_req=4'b0100 -> o_gnt=4'b0100 and o_cs_n=4'b1011 one cycle later.
- Owner 2 sends 0xA5; SPI model returns done with rdata 0x3C after 8 cycles -> o_spi_start pulse with o_spi_wdata=0xA5, then o_rvalid[2] pulse with o_rdata=0x3C.
- i_req=4'b1111 held, each owner sending one byte unlocked -> grant order 0,1,2,3,0 with a 2-cycle all-high o_cs_n gap between owners.
- Owner 1 holds i_lock across 3 bytes while i_req[0] is high -> o_cs_n[1] stays low through all 3 bytes; owner 0 is granted only after release.
- i_rst asserted in WAIT_DONE, then i_spi_done the next cycle -> no o_rvalid; o_cs_n all 1; o_gnt 0.
- Timeout with SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner locks, sends nothing -> o_timeout pulses after 16 GRANT cycles and a release follows. Without SPI_ARB_TIMEOUT_EN -> the grant holds for 100 cycles.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and sizing for the SPI bus arbiter.
//   arb_state_t : arbiter sequencing states
//   N_REQ_MAX   : largest supported requester count
//   IDX_W       : width of an owner / pointer index
package spi_arb_pkg;

   localparam int unsigned N_REQ_MAX = 8;
   localparam int unsigned IDX_W     = $clog2(N_REQ_MAX);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT_DONE,
      RELEASE
   } arb_state_t;

endpackage

// File: rtl/spi_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ.
//   req   : request vector
//   ptr   : round-robin start index
//   gnt   : one-hot winner (zero when no request)
//   idx   : winner index
//   valid : at least one request present
module rr_picker
   import spi_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [N_REQ-1:0] rot;
   int unsigned      sum;

   // Rotate so bit 0 of rot is the request at ptr, then take the first set bit.
   always_comb begin
      rot   = N_REQ'({req, req} >> ptr);
      valid = 1'b0;
      idx   = '0;
      gnt   = '0;
      sum   = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!valid && rot[i]) begin
            valid = 1'b1;
            sum   = 32'(ptr) + i;
            if (sum >= N_REQ) begin
               sum = sum - N_REQ;
            end
            idx = IDX_W'(sum);
         end
      end
      if (valid) begin
         gnt = N_REQ'(1) << idx;
      end
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master between N_REQ requesters.
// Optional feature macro: SPI_ARB_TIMEOUT_EN (idle-grant timeout with forced release).
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_req/i_lock/i_wvalid : per-requester request, bus lock, byte-valid
//   i_wdata               : byte per requester, requester k at [8k+7:8k]
//   o_wready              : combinational byte accept, owner only
//   o_rvalid/o_rdata      : received byte pulse to owner, shared data
//   o_gnt/o_cs_n          : one-hot grant, active-low chip selects
//   o_spi_start/o_spi_wdata, i_spi_busy/i_spi_done/i_spi_rdata : SPI master side
//   o_timeout             : pulse on forced release
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [N_REQ-1:0]   i_lock,
   input  logic [N_REQ-1:0]   i_wvalid,
   input  logic [N_REQ*8-1:0] i_wdata,
   output logic [N_REQ-1:0]   o_wready,
   output logic [N_REQ-1:0]   o_rvalid,
   output logic [7:0]         o_rdata,
   output logic [N_REQ-1:0]   o_gnt,
   output logic [N_REQ-1:0]   o_cs_n,
   output logic               o_spi_start,
   output logic [7:0]         o_spi_wdata,
   input  logic               i_spi_busy,
   input  logic               i_spi_done,
   input  logic [7:0]         i_spi_rdata,
   output logic               o_timeout
);

   if (N_REQ < 2 || N_REQ > N_REQ_MAX || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("spi_bus_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
   end

   arb_state_t       state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] ptr;

   logic [N_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;

   logic             own_wvalid;
   logic             own_lock;
   logic [7:0]       own_wdata;
   logic             handshake;
   logic             release_req;
   logic             to_hit;

   rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req   (i_req),
      .ptr   (ptr),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // o_gnt is the registered one-hot owner, so it masks out non-owner inputs.
   assign own_wvalid  = |(i_wvalid & o_gnt);
   assign own_lock    = |(i_lock & o_gnt);
   assign handshake   = (state == GRANT) && own_wvalid && !i_spi_busy;
   assign release_req = (state == GRANT) && !own_lock && !own_wvalid;
   assign o_wready    = handshake ? o_gnt : '0;

   // Owner byte select.
   always_comb begin
      own_wdata = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (o_gnt[i]) begin
            own_wdata = i_wdata[8*i +: 8];
         end
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt;

   assign to_hit = (state == GRANT) && !handshake && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Counts idle GRANT cycles; cleared by a handshake or by leaving GRANT.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         to_cnt    <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= to_hit;
         if ((state == GRANT) && !handshake && !release_req && !to_hit) begin
            to_cnt <= to_cnt + TO_W'(1);
         end else begin
            to_cnt <= '0;
         end
      end
   end
`else
   assign to_hit    = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // Arbitration and transfer sequencing.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         owner       <= '0;
         ptr         <= '0;
         o_gnt       <= '0;
         o_cs_n      <= '1;
         o_rvalid    <= '0;
         o_rdata     <= '0;
         o_spi_start <= 1'b0;
         o_spi_wdata <= '0;
      end else begin
         o_spi_start <= 1'b0;
         o_rvalid    <= '0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner  <= pick_idx;
                  o_gnt  <= pick_gnt;
                  o_cs_n <= ~pick_gnt;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               if (handshake) begin
                  o_spi_wdata <= own_wdata;
                  o_spi_start <= 1'b1;
                  state       <= WAIT_DONE;
               end else if (release_req || to_hit) begin
                  o_gnt  <= '0;
                  o_cs_n <= '1;
                  state  <= RELEASE;
               end
            end
            WAIT_DONE: begin
               if (i_spi_done) begin
                  o_rdata  <= i_spi_rdata;
                  o_rvalid <= o_gnt;
                  state    <= GRANT;
               end
            end
            RELEASE: begin
               ptr   <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter (N_REQ=4, TIMEOUT_CYCLES=16).
module tb_spi_bus_arbiter;

   localparam int unsigned N = 4;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic [N-1:0] i_req = '0;
   logic [N-1:0] i_lock = '0;
   logic [N-1:0] i_wvalid = '0;
   logic [N*8-1:0] i_wdata = '0;
   logic [N-1:0] o_wready;
   logic [N-1:0] o_rvalid;
   logic [7:0]   o_rdata;
   logic [N-1:0] o_gnt;
   logic [N-1:0] o_cs_n;
   logic         o_spi_start;
   logic [7:0]   o_spi_wdata;
   logic         i_spi_busy;
   logic         i_spi_done;
   logic [7:0]   i_spi_rdata;
   logic         o_timeout;

   logic         model_busy;
   logic         model_done;
   logic [3:0]   model_cnt;
   logic [7:0]   model_rdata_q;
   logic [7:0]   model_ret = 8'h00;
   logic         force_done = 1'b0;
   logic [7:0]   force_rdata = 8'h00;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   assign i_spi_busy  = model_busy;
   assign i_spi_done  = model_done | force_done;
   assign i_spi_rdata = force_done ? force_rdata : model_rdata_q;

   spi_bus_arbiter #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (i_req),
      .i_lock      (i_lock),
      .i_wvalid    (i_wvalid),
      .i_wdata     (i_wdata),
      .o_wready    (o_wready),
      .o_rvalid    (o_rvalid),
      .o_rdata     (o_rdata),
      .o_gnt       (o_gnt),
      .o_cs_n      (o_cs_n),
      .o_spi_start (o_spi_start),
      .o_spi_wdata (o_spi_wdata),
      .i_spi_busy  (i_spi_busy),
      .i_spi_done  (i_spi_done),
      .i_spi_rdata (i_spi_rdata),
      .o_timeout   (o_timeout)
   );

   // SPI master model: busy after start, done pulse 9 edges after the start edge.
   always @(posedge i_clk) begin
      if (i_rst) begin
         model_busy    <= 1'b0;
         model_done    <= 1'b0;
         model_cnt     <= '0;
         model_rdata_q <= '0;
      end else begin
         model_done <= 1'b0;
         if (o_spi_start && !model_busy) begin
            model_busy <= 1'b1;
            model_cnt  <= 4'd7;
         end else if (model_busy) begin
            if (model_cnt == 4'd0) begin
               model_busy    <= 1'b0;
               model_done    <= 1'b1;
               model_rdata_q <= model_ret;
            end else begin
               model_cnt <= model_cnt - 4'd1;
            end
         end
      end
   end

   // Advance one cycle and check the grant / chip-select invariants.
   task automatic tick();
      @(posedge i_clk);
      #1;
      n_checks++;
      if (!$onehot0(o_gnt)) begin
         n_fail++;
         $display("FAIL gnt_onehot0 got %b required one-hot or zero", o_gnt);
      end
      n_checks++;
      if (o_cs_n !== ~o_gnt) begin
         n_fail++;
         $display("FAIL cs_n_vs_gnt got cs_n=%b required %b", o_cs_n, ~o_gnt);
      end
   endtask

   task automatic wait_rvalid(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         tick();
         lat++;
         if (o_rvalid !== '0) ok = 1'b1;
      end
   endtask

   task automatic wait_gnt(output int gap, output bit ok);
      gap = 0;
      ok  = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         tick();
         if (o_gnt !== '0) ok = 1'b1;
         else if (o_cs_n === '1) gap++;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (o_gnt !== 4'b0000 || o_cs_n !== 4'b1111) begin
         n_fail++;
         $display("FAIL reset_gnt_cs got gnt=%b cs_n=%b required 0000/1111", o_gnt, o_cs_n);
      end
      n_checks++;
      if (o_wready !== 4'b0000 || o_rvalid !== 4'b0000 || o_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rd got wready=%b rvalid=%b rdata=%h required 0/0/00", o_wready, o_rvalid, o_rdata);
      end
      n_checks++;
      if (o_spi_start !== 1'b0 || o_spi_wdata !== 8'h00 || o_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_spi got start=%b wdata=%h timeout=%b required 0/00/0", o_spi_start, o_spi_wdata, o_timeout);
      end
      i_rst = 1'b0;
      tick();
   endtask

   task automatic test_grant_and_byte();
      int lat;
      bit ok;
      i_req = 4'b0100;
      tick();
      n_checks++;
      if (o_gnt !== 4'b0100 || o_cs_n !== 4'b1011) begin
         n_fail++;
         $display("FAIL grant_latency got gnt=%b cs_n=%b required 0100/1011", o_gnt, o_cs_n);
      end
      i_lock = 4'b0100;
      i_wdata[23:16] = 8'hA5;
      i_wvalid = 4'b0101;
      model_ret = 8'h3C;
      #1;
      n_checks++;
      if (o_wready !== 4'b0100) begin
         n_fail++;
         $display("FAIL wready_owner got %b required 0100", o_wready);
      end
      tick();
      i_wvalid = 4'b0000;
      n_checks++;
      if (o_spi_start !== 1'b1 || o_spi_wdata !== 8'hA5) begin
         n_fail++;
         $display("FAIL spi_start got start=%b wdata=%h required 1/a5", o_spi_start, o_spi_wdata);
      end
      wait_rvalid(lat, ok);
      n_checks++;
      if (!ok || lat != 10) begin
         n_fail++;
         $display("FAIL rvalid_latency got ok=%0d lat=%0d required 1/10", ok, lat);
      end
      n_checks++;
      if (o_rvalid !== 4'b0100 || o_rdata !== 8'h3C) begin
         n_fail++;
         $display("FAIL rvalid_data got rvalid=%b rdata=%h required 0100/3c", o_rvalid, o_rdata);
      end
      force_done = 1'b1;
      force_rdata = 8'hEE;
      tick();
      force_done = 1'b0;
      n_checks++;
      if (o_rvalid !== 4'b0000 || o_gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL rvalid_pulse got rvalid=%b gnt=%b required 0000/0100", o_rvalid, o_gnt);
      end
      tick();
      n_checks++;
      if (o_rvalid !== 4'b0000 || o_rdata !== 8'h3C) begin
         n_fail++;
         $display("FAIL done_ignored_in_grant got rvalid=%b rdata=%h required 0000/3c", o_rvalid, o_rdata);
      end
      i_lock = '0;
      i_req = '0;
      tick();
      n_checks++;
      if (o_gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL release_after_unlock got gnt=%b required 0000", o_gnt);
      end
      tick();
      tick();
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      int gap;
      int lat;
      bit ok;
      logic [N-1:0] exp;
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      i_req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         exp = 4'(1) << order[g];
         wait_gnt(gap, ok);
         n_checks++;
         if (!ok || o_gnt !== exp) begin
            n_fail++;
            $display("FAIL rr_order[%0d] got gnt=%b ok=%0d required %b", g, o_gnt, ok, exp);
         end
         if (g > 0) begin
            n_checks++;
            if (gap != 2) begin
               n_fail++;
               $display("FAIL rr_cs_gap[%0d] got %0d cycles required 2", g, gap);
            end
         end
         i_wdata[8*order[g] +: 8] = 8'h10 + 8'(g);
         i_wvalid = exp;
         tick();
         i_wvalid = '0;
         n_checks++;
         if (o_spi_start !== 1'b1 || o_spi_wdata !== 8'h10 + 8'(g)) begin
            n_fail++;
            $display("FAIL rr_wdata[%0d] got start=%b wdata=%h required 1/%h", g, o_spi_start, o_spi_wdata, 8'h10 + 8'(g));
         end
         wait_rvalid(lat, ok);
         n_checks++;
         if (!ok || o_rvalid !== exp) begin
            n_fail++;
            $display("FAIL rr_rvalid[%0d] got rvalid=%b ok=%0d required %b", g, o_rvalid, ok, exp);
         end
      end
      i_req = '0;
      tick();
      tick();
      tick();
   endtask

   task automatic test_lock();
      int gap;
      int lat;
      bit ok;
      i_req = 4'b0011;
      i_lock = 4'b0010;
      tick();
      n_checks++;
      if (o_gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL lock_grant got gnt=%b required 0010", o_gnt);
      end
      for (int b = 0; b < 3; b++) begin
         i_wdata[15:8] = 8'h50 + 8'(b);
         i_wvalid = 4'b0011;
         #1;
         n_checks++;
         if (o_wready !== 4'b0010) begin
            n_fail++;
            $display("FAIL lock_wready[%0d] got %b required 0010", b, o_wready);
         end
         tick();
         i_wvalid = '0;
         if (b == 2) i_lock = '0;
         n_checks++;
         if (o_spi_wdata !== 8'h50 + 8'(b)) begin
            n_fail++;
            $display("FAIL lock_wdata[%0d] got %h required %h", b, o_spi_wdata, 8'h50 + 8'(b));
         end
         wait_rvalid(lat, ok);
         n_checks++;
         if (!ok || o_rvalid !== 4'b0010 || o_cs_n !== 4'b1101) begin
            n_fail++;
            $display("FAIL lock_hold[%0d] got rvalid=%b cs_n=%b ok=%0d required 0010/1101", b, o_rvalid, o_cs_n, ok);
         end
      end
      tick();
      n_checks++;
      if (o_gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL lock_release got gnt=%b required 0000", o_gnt);
      end
      wait_gnt(gap, ok);
      n_checks++;
      if (!ok || o_gnt !== 4'b0001 || gap != 1) begin
         n_fail++;
         $display("FAIL lock_next_owner got gnt=%b gap_after=%0d required 0001/1", o_gnt, gap);
      end
      i_req = '0;
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset_mid_transfer();
      i_req = 4'b0010;
      tick();
      n_checks++;
      if (o_gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL mid_grant got gnt=%b required 0010", o_gnt);
      end
      i_req = '0;
      i_lock = 4'b0010;
      i_wvalid = 4'b0010;
      tick();
      i_wvalid = '0;
      i_rst = 1'b1;
      tick();
      n_checks++;
      if (o_gnt !== 4'b0000 || o_cs_n !== 4'b1111 || o_spi_start !== 1'b0 || o_spi_wdata !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset got gnt=%b cs_n=%b start=%b wdata=%h required 0000/1111/0/00", o_gnt, o_cs_n, o_spi_start, o_spi_wdata);
      end
      i_rst = 1'b0;
      i_lock = '0;
      force_done = 1'b1;
      force_rdata = 8'hEE;
      tick();
      force_done = 1'b0;
      tick();
      n_checks++;
      if (o_rvalid !== 4'b0000 || o_rdata !== 8'h00 || o_gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_done_dropped got rvalid=%b rdata=%h gnt=%b required 0000/00/0000", o_rvalid, o_rdata, o_gnt);
      end
   endtask

   task automatic test_timeout();
      i_req = 4'b0100;
      i_lock = 4'b0100;
      tick();
      n_checks++;
      if (o_gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL to_grant got gnt=%b required 0100", o_gnt);
      end
`ifdef SPI_ARB_TIMEOUT_EN
      begin
         int n;
         bit ok;
         n = 0;
         ok = 1'b0;
         for (int k = 0; k < 40 && !ok; k++) begin
            tick();
            n++;
            if (o_timeout === 1'b1) ok = 1'b1;
         end
         n_checks++;
         if (!ok || n != 16 || o_gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_pulse got ok=%0d cycles=%0d gnt=%b required 1/16/0000", ok, n, o_gnt);
         end
         tick();
         n_checks++;
         if (o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_one_cycle got %b required 0", o_timeout);
         end
      end
`else
      begin
         int bad;
         bad = 0;
         for (int k = 0; k < 100; k++) begin
            tick();
            if (o_gnt !== 4'b0100 || o_timeout !== 1'b0) bad++;
         end
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL lock_holds_100 got %0d bad cycles required 0", bad);
         end
      end
`endif
      i_req = '0;
      i_lock = '0;
      tick();
      tick();
      tick();
      n_checks++;
      if (o_gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL to_cleanup got gnt=%b required 0000", o_gnt);
      end
   endtask

   initial begin
      test_reset();
      test_grant_and_byte();
      test_round_robin();
      test_lock();
      test_reset_mid_transfer();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
